gdp_stream: RTL and testbench

//  Parametrised streaming Gaussian discriminant: ln_p = k - sum_i omega_i*(x_i-mean_i)^2 per class vector.

---
 rtl/gdp_stream.sv | 301 ++++++++++++++++++++++++++++++
 tb/tb_gdp_stream.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gdp_stream.sv
// Streaming Gaussian discriminant: ln_p = k - sum(omega*(x-mean)^2) per class vector,
// with saturation tracking, first/last framing checks and a per-frame argmax.
module gdp_stream #(
   parameter int W    = 16,
   parameter int FRAC = 8,
   parameter int ACCW = 24,
   parameter int CLSW = 3
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   input  logic                   in_first,
   input  logic                   in_last,
   input  logic                   in_frame_end,
   input  logic [CLSW-1:0]        in_class,
   input  logic signed [W-1:0]    x,
   input  logic signed [W-1:0]    mean,
   input  logic signed [W-1:0]    omega,
   input  logic signed [W-1:0]    k,
   output logic                   out_valid,
   output logic signed [W-1:0]    ln_p,
   output logic [CLSW-1:0]        out_class,
   output logic                   ln_sat,
   output logic                   best_valid,
   output logic [CLSW-1:0]        best_class,
   output logic signed [W-1:0]    best_ln_p,
   output logic                   err
);

   localparam int SQW  = 2*W + 2;
   localparam int WIDE = ACCW + W;
   localparam int AW1  = ACCW + 1;

   // {clamped, value}; wide enough inputs for every product and sum in the pipe
   function automatic logic [ACCW:0] sat_acc(input logic signed [WIDE-1:0] v);
      logic [ACCW:0] r;
      if (v[WIDE-1:ACCW-1] == {(WIDE-ACCW+1){v[WIDE-1]}})
         r = {1'b0, v[ACCW-1:0]};
      else if (v[WIDE-1])
         r = {1'b1, 1'b1, {(ACCW-1){1'b0}}};
      else
         r = {1'b1, 1'b0, {(ACCW-1){1'b1}}};
      return r;
   endfunction

   function automatic logic [W:0] sat_w(input logic signed [AW1-1:0] v);
      logic [W:0] r;
      if (v[AW1-1:W-1] == {(AW1-W+1){v[AW1-1]}})
         r = {1'b0, v[W-1:0]};
      else if (v[AW1-1])
         r = {1'b1, 1'b1, {(W-1){1'b0}}};
      else
         r = {1'b1, 1'b0, {(W-1){1'b1}}};
      return r;
   endfunction

   typedef enum logic {S_IDLE, S_ACCUM} state_t;

   state_t state_q, state_d;
   logic   accept, err_d, err_q;

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      err_d   = 1'b0;
      if (in_valid) begin
         case (state_q)
            S_IDLE: begin
               if (in_first) begin
                  accept  = 1'b1;
                  state_d = in_last ? S_IDLE : S_ACCUM;
               end else begin
                  err_d = 1'b1;
               end
            end
            S_ACCUM: begin
               // a new first aborts the open vector; the restart flag resets the accumulator
               accept  = 1'b1;
               err_d   = in_first;
               state_d = in_last ? S_IDLE : S_ACCUM;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         err_q   <= err_d;
      end
   end

   // ---- stage p1: difference, exact in W+1 bits
   logic                   vld_p1_q, first_p1_q, last_p1_q, fe_p1_q;
   logic [CLSW-1:0]        cls_p1_q;
   logic signed [W-1:0]    k_p1_q, omega_p1_q;
   logic signed [W:0]      diff_d, diff_p1_q;

   assign diff_d = $signed({x[W-1], x}) - $signed({mean[W-1], mean});

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld_p1_q   <= 1'b0;
         first_p1_q <= 1'b0;
         last_p1_q  <= 1'b0;
         fe_p1_q    <= 1'b0;
         cls_p1_q   <= '0;
         k_p1_q     <= '0;
         omega_p1_q <= '0;
         diff_p1_q  <= '0;
      end else begin
         vld_p1_q   <= accept;
         first_p1_q <= in_first;
         last_p1_q  <= in_last;
         fe_p1_q    <= in_frame_end;
         cls_p1_q   <= in_class;
         k_p1_q     <= k;
         omega_p1_q <= omega;
         diff_p1_q  <= diff_d;
      end
   end

   // ---- stage p2: square, rescale, clamp to accumulator width
   logic signed [SQW-1:0]  sq_full, sq_sh;
   logic [ACCW:0]          sq_res;
   logic                   vld_p2_q, first_p2_q, last_p2_q, fe_p2_q, sat_p2_q;
   logic [CLSW-1:0]        cls_p2_q;
   logic signed [W-1:0]    k_p2_q, omega_p2_q;
   logic signed [ACCW-1:0] sq_p2_q;

   assign sq_full = SQW'(diff_p1_q) * SQW'(diff_p1_q);
   assign sq_sh   = sq_full >>> FRAC;
   assign sq_res  = sat_acc(WIDE'(sq_sh));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld_p2_q   <= 1'b0;
         first_p2_q <= 1'b0;
         last_p2_q  <= 1'b0;
         fe_p2_q    <= 1'b0;
         sat_p2_q   <= 1'b0;
         cls_p2_q   <= '0;
         k_p2_q     <= '0;
         omega_p2_q <= '0;
         sq_p2_q    <= '0;
      end else begin
         vld_p2_q   <= vld_p1_q;
         first_p2_q <= first_p1_q;
         last_p2_q  <= last_p1_q;
         fe_p2_q    <= fe_p1_q;
         sat_p2_q   <= sq_res[ACCW];
         cls_p2_q   <= cls_p1_q;
         k_p2_q     <= k_p1_q;
         omega_p2_q <= omega_p1_q;
         sq_p2_q    <= sq_res[ACCW-1:0];
      end
   end

   // ---- stage p3: weight by precision (may be negative), rescale, clamp
   logic signed [WIDE-1:0] sc_full, sc_sh;
   logic [ACCW:0]          sc_res;
   logic                   vld_p3_q, first_p3_q, last_p3_q, fe_p3_q, sat_p3_q;
   logic [CLSW-1:0]        cls_p3_q;
   logic signed [W-1:0]    k_p3_q;
   logic signed [ACCW-1:0] sc_p3_q;

   assign sc_full = WIDE'(sq_p2_q) * WIDE'(omega_p2_q);
   assign sc_sh   = sc_full >>> FRAC;
   assign sc_res  = sat_acc(sc_sh);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld_p3_q   <= 1'b0;
         first_p3_q <= 1'b0;
         last_p3_q  <= 1'b0;
         fe_p3_q    <= 1'b0;
         sat_p3_q   <= 1'b0;
         cls_p3_q   <= '0;
         k_p3_q     <= '0;
         sc_p3_q    <= '0;
      end else begin
         vld_p3_q   <= vld_p2_q;
         first_p3_q <= first_p2_q;
         last_p3_q  <= last_p2_q;
         fe_p3_q    <= fe_p2_q;
         sat_p3_q   <= sat_p2_q | sc_res[ACCW];
         cls_p3_q   <= cls_p2_q;
         k_p3_q     <= k_p2_q;
         sc_p3_q    <= sc_res[ACCW-1:0];
      end
   end

   // ---- stage p4: accumulate; k and tag latched with the first element
   logic signed [AW1-1:0]  sum_d;
   logic [ACCW:0]          add_res;
   logic signed [ACCW-1:0] acc_q;
   logic signed [W-1:0]    kv_q;
   logic [CLSW-1:0]        clsv_q;
   logic                   satv_q, emit_p4_q, fe_p4_q;

   assign sum_d   = AW1'(acc_q) + AW1'(sc_p3_q);
   assign add_res = sat_acc(WIDE'(sum_d));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc_q     <= '0;
         kv_q      <= '0;
         clsv_q    <= '0;
         satv_q    <= 1'b0;
         emit_p4_q <= 1'b0;
         fe_p4_q   <= 1'b0;
      end else begin
         emit_p4_q <= vld_p3_q & last_p3_q;
         fe_p4_q   <= vld_p3_q & last_p3_q & fe_p3_q;
         if (vld_p3_q) begin
            if (first_p3_q) begin
               acc_q  <= sc_p3_q;
               kv_q   <= k_p3_q;
               clsv_q <= cls_p3_q;
               satv_q <= sat_p3_q;
            end else begin
               acc_q  <= add_res[ACCW-1:0];
               satv_q <= satv_q | sat_p3_q | add_res[ACCW];
            end
         end
      end
   end

   // ---- stage p5: ln_p = k - acc, clamped to W
   logic signed [AW1-1:0]  ln_diff;
   logic [W:0]             ln_res;
   logic                   out_valid_q, ln_sat_q, fe_p5_q;
   logic signed [W-1:0]    ln_p_q;
   logic [CLSW-1:0]        out_class_q;

   assign ln_diff = AW1'(kv_q) - AW1'(acc_q);
   assign ln_res  = sat_w(ln_diff);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         ln_sat_q    <= 1'b0;
         fe_p5_q     <= 1'b0;
         ln_p_q      <= '0;
         out_class_q <= '0;
      end else begin
         out_valid_q <= emit_p4_q;
         fe_p5_q     <= fe_p4_q;
         if (emit_p4_q) begin
            ln_p_q      <= ln_res[W-1:0];
            ln_sat_q    <= satv_q | ln_res[W];
            out_class_q <= clsv_q;
         end
      end
   end

   // ---- stage p6: running argmax; published copy only moves at frame end
   logic                   new_frame_q, take, best_valid_q;
   logic signed [W-1:0]    run_ln_q, cand_ln, best_ln_q;
   logic [CLSW-1:0]        run_cls_q, cand_cls, best_cls_q;

   assign take     = new_frame_q || (ln_p_q > run_ln_q);
   assign cand_ln  = take ? ln_p_q : run_ln_q;
   assign cand_cls = take ? out_class_q : run_cls_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         new_frame_q  <= 1'b1;
         run_ln_q     <= '0;
         run_cls_q    <= '0;
         best_valid_q <= 1'b0;
         best_ln_q    <= '0;
         best_cls_q   <= '0;
      end else begin
         best_valid_q <= out_valid_q & fe_p5_q;
         if (out_valid_q) begin
            run_ln_q    <= cand_ln;
            run_cls_q   <= cand_cls;
            new_frame_q <= fe_p5_q;
            if (fe_p5_q) begin
               best_ln_q  <= cand_ln;
               best_cls_q <= cand_cls;
            end
         end
      end
   end

   assign out_valid  = out_valid_q;
   assign ln_p       = ln_p_q;
   assign out_class  = out_class_q;
   assign ln_sat     = ln_sat_q;
   assign best_valid = best_valid_q;
   assign best_class = best_cls_q;
   assign best_ln_p  = best_ln_q;
   assign err        = err_q;

endmodule

// File: tb/tb_gdp_stream.sv
// Scoreboard bench for gdp_stream: a vector-level reference model queues expected results
// tagged with their due cycle; a negedge monitor pops and compares whatever the DUT presents.
module tb_gdp_stream;
   localparam int W    = 16;
   localparam int FRAC = 8;
   localparam int ACCW = 24;
   localparam int CLSW = 3;

   logic                clk = 1'b0;
   logic                reset;
   logic                in_valid, in_first, in_last, in_frame_end;
   logic [CLSW-1:0]     in_class;
   logic signed [W-1:0] x, mean, omega, k;
   logic                out_valid, ln_sat, best_valid, err;
   logic signed [W-1:0] ln_p, best_ln_p;
   logic [CLSW-1:0]     out_class, best_class;

   gdp_stream #(.W(W), .FRAC(FRAC), .ACCW(ACCW), .CLSW(CLSW)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_first(in_first),
      .in_last(in_last), .in_frame_end(in_frame_end), .in_class(in_class),
      .x(x), .mean(mean), .omega(omega), .k(k),
      .out_valid(out_valid), .ln_p(ln_p), .out_class(out_class), .ln_sat(ln_sat),
      .best_valid(best_valid), .best_class(best_class), .best_ln_p(best_ln_p), .err(err)
   );

   always #5 clk = ~clk;

   longint cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   typedef struct {longint cyc; longint ln; int cls; bit sat;} exp_t;
   typedef struct {longint cyc; longint ln; int cls;} best_t;
   typedef struct {longint x; longint m; longint o;} elem_t;

   exp_t   out_q[$];
   best_t  best_q[$];
   longint err_q[$];

   elem_t  vec[$];
   bit     active = 0;
   longint vk;
   int     vcls;
   bit     frame_new = 1;
   longint run_ln;
   int     run_cls;

   function automatic void check(string nm, logic signed [63:0] act, logic signed [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                  nm, act, act, req, req, cyc);
      end
   endfunction

   function automatic longint clampv(longint v, int bits);
      longint mx;
      mx = (longint'(1) <<< (bits - 1)) - 1;
      if (v > mx) return mx;
      if (v < -mx - 1) return -mx - 1;
      return v;
   endfunction

   // Whole-vector evaluation from the arithmetic definition, then argmax bookkeeping
   function automatic void finish_vec(longint c, bit fe);
      longint acc, d, sq, sc, ln;
      bit     s;
      acc = 0;
      s   = 0;
      foreach (vec[i]) begin
         d  = vec[i].x - vec[i].m;
         sq = (d * d) >>> FRAC;
         if (clampv(sq, ACCW) != sq) s = 1;
         sq = clampv(sq, ACCW);
         sc = (sq * vec[i].o) >>> FRAC;
         if (clampv(sc, ACCW) != sc) s = 1;
         sc = clampv(sc, ACCW);
         if (i == 0) acc = sc;
         else begin
            acc = acc + sc;
            if (clampv(acc, ACCW) != acc) s = 1;
            acc = clampv(acc, ACCW);
         end
      end
      ln = vk - acc;
      if (clampv(ln, W) != ln) s = 1;
      ln = clampv(ln, W);
      out_q.push_back('{c + 5, ln, vcls, s});
      if (frame_new || ln > run_ln) begin
         run_ln  = ln;
         run_cls = vcls;
      end
      frame_new = fe;
      if (fe) best_q.push_back('{c + 6, run_ln, run_cls});
   endfunction

   function automatic void model(bit v, bit f, bit l, bit fe, int cls,
                                 longint xx, longint mm, longint oo, longint kk);
      if (!v) return;
      if (!f && !active) begin
         err_q.push_back(cyc + 1);
         return;
      end
      if (f) begin
         if (active) err_q.push_back(cyc + 1);
         vec.delete();
         vk     = kk;
         vcls   = cls;
         active = 1;
      end
      vec.push_back('{xx, mm, oo});
      if (l) begin
         finish_vec(cyc, fe);
         active = 0;
      end
   endfunction

   task automatic drive(bit v, bit f, bit l, bit fe, int cls,
                        logic signed [W-1:0] xx, logic signed [W-1:0] mm,
                        logic signed [W-1:0] oo, logic signed [W-1:0] kk);
      in_valid     = v;
      in_first     = f;
      in_last      = l;
      in_frame_end = fe;
      in_class     = CLSW'(cls);
      x            = xx;
      mean         = mm;
      omega        = oo;
      k            = kk;
      model(v, f, l, fe, cls, xx, mm, oo, kk);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   exp_t  eo;
   best_t eb;
   longint ec;

   always @(negedge clk) begin
      if (reset) begin
         check("outputs_in_reset",
               {out_valid, best_valid, err, ln_sat, ln_p, best_ln_p, out_class, best_class}, 0);
      end else begin
         if (out_valid) begin
            if (out_q.size() == 0) check("unexpected_out_valid", 1, 0);
            else begin
               eo = out_q.pop_front();
               check("out_cycle", cyc, eo.cyc);
               check("ln_p", ln_p, eo.ln);
               check("out_class", out_class, eo.cls);
               check("ln_sat", ln_sat, eo.sat);
            end
         end else if (out_q.size() != 0 && out_q[0].cyc <= cyc) begin
            eo = out_q.pop_front();
            check("missing_out_valid", 0, 1);
         end
         if (best_valid) begin
            if (best_q.size() == 0) check("unexpected_best_valid", 1, 0);
            else begin
               eb = best_q.pop_front();
               check("best_cycle", cyc, eb.cyc);
               check("best_ln_p", best_ln_p, eb.ln);
               check("best_class", best_class, eb.cls);
            end
         end else if (best_q.size() != 0 && best_q[0].cyc <= cyc) begin
            eb = best_q.pop_front();
            check("missing_best_valid", 0, 1);
         end
         if (err) begin
            if (err_q.size() == 0) check("unexpected_err", 1, 0);
            else begin
               ec = err_q.pop_front();
               check("err_cycle", cyc, ec);
            end
         end else if (err_q.size() != 0 && err_q[0] <= cyc) begin
            ec = err_q.pop_front();
            check("missing_err", 0, 1);
         end
      end
   end

   function automatic logic signed [W-1:0] rnd_val(bit full, int span);
      if (full) return W'($urandom);
      return W'(int'($urandom_range(0, 2 * span)) - span);
   endfunction

   initial begin
      reset = 1'b1;
      in_valid = 0; in_first = 0; in_last = 0; in_frame_end = 0;
      in_class = '0; x = '0; mean = '0; omega = '0; k = '0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;

      // single-element vector and two-element vectors, with and without a bubble
      drive(1, 1, 1, 0, 1, 16'h0300, 16'h0100, 16'h0080, 16'h0A00);
      idle(6);
      drive(1, 1, 0, 0, 2, 16'h0300, 16'h0100, 16'h0080, 16'h0A00);
      drive(1, 0, 1, 0, 2, 16'h0300, 16'h0100, 16'h0080, 16'h0A00);
      idle(6);
      drive(1, 1, 0, 0, 3, 16'h0300, 16'h0100, 16'h0080, 16'h0A00);
      drive(0, 1, 1, 1, 7, 16'h7FFF, 16'h0000, 16'h0100, 16'h0000);
      drive(1, 0, 1, 0, 3, 16'h0300, 16'h0100, 16'h0080, 16'h0A00);
      idle(6);
      // full-scale difference saturates; also closes the frame opened above
      drive(1, 1, 1, 1, 4, 16'h7FFF, 16'h8000, 16'h0100, 16'h0000);
      idle(7);
      // three-class frame with a tie at the top, back to back
      drive(1, 1, 1, 0, 0, 16'h0000, 16'h0000, 16'h0100, 16'h0200);
      drive(1, 1, 1, 0, 1, 16'h0000, 16'h0000, 16'h0100, 16'h0500);
      drive(1, 1, 1, 1, 2, 16'h0000, 16'h0000, 16'h0100, 16'h0500);
      idle(8);
      // framing errors: stray sample in idle, then a restart mid-vector
      drive(1, 0, 0, 0, 5, 16'h0100, 16'h0000, 16'h0100, 16'h0100);
      drive(1, 0, 1, 0, 5, 16'h0100, 16'h0000, 16'h0100, 16'h0100);
      drive(1, 1, 0, 0, 5, 16'h0400, 16'h0000, 16'h0100, 16'h0100);
      drive(1, 0, 0, 0, 5, 16'h0400, 16'h0000, 16'h0100, 16'h0100);
      drive(1, 1, 0, 0, 6, 16'h0100, 16'h0000, 16'h0100, 16'h0300);
      drive(1, 0, 1, 1, 6, 16'h0080, 16'h0000, 16'hFF00, 16'h0300);
      idle(8);

      // reset two cycles after a last: result must never appear
      drive(1, 1, 0, 0, 3, 16'h0200, 16'h0000, 16'h0100, 16'h0100);
      drive(1, 0, 1, 1, 3, 16'h0200, 16'h0000, 16'h0100, 16'h0100);
      idle(2);
      reset = 1'b1;
      out_q.delete();
      best_q.delete();
      err_q.delete();
      vec.delete();
      active    = 0;
      frame_new = 1;
      idle(3);
      reset = 1'b0;
      @(negedge clk);
      check("outputs_after_reset",
            {out_valid, best_valid, err, ln_sat, ln_p, best_ln_p, out_class, best_class}, 0);
      @(posedge clk);
      #1;
      idle(6);

      // randomized traffic: bubbles, malformed framing, mixed small/full-scale data
      for (int n = 0; n < 3000; n++) begin
         bit full;
         full = ($urandom % 8) == 0;
         drive(($urandom % 5) != 0, ($urandom % 4) == 0, ($urandom % 3) == 0,
               ($urandom % 3) == 0, int'($urandom % 8),
               rnd_val(full, 1024), rnd_val(full, 1024), rnd_val(full, 512),
               rnd_val(full, 4096));
      end
      idle(10);

      check("pending_out_results", out_q.size(), 0);
      check("pending_best_results", best_q.size(), 0);
      check("pending_err_pulses", err_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
